// File: rtl/tlul_pkg.sv
// Shared encodings and width defaults for the TL-UL command front-end.
package tlul_pkg;

    localparam int TLUL_ADDR_W = 32;
    localparam int TLUL_DATA_W = 32;
    localparam int TLUL_MASK_W = TLUL_DATA_W / 8;
    localparam int TLUL_SIZE_W = 3;

    typedef enum logic [1:0] {
        TT_GET        = 2'b00,
        TT_PUTFULL    = 2'b01,
        TT_PUTPARTIAL = 2'b10,
        TT_RSVD       = 2'b11
    } trans_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } cmd_state_e;

endpackage

// File: rtl/tlul_sync_fifo.sv
// Generic synchronous FIFO, DEPTH a power of two, head visible on pop_dat.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty.
module tlul_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_24,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk_24 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_24) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/tlul_cmd_queue.sv
// Queues CPU commands and issues them one at a time to tlul_system; TLUL_CMD_TIMEOUT_EN adds a WAIT watchdog.
// Latency: accept at N -> start_trans at N+2; trans_done at M -> rsp_valid at M+1.
// Backpressure: cmd_ready low only when the FIFO is full; rsp_ready low stalls issue in RESP.
module tlul_cmd_queue
    import tlul_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int ADDR_WIDTH     = TLUL_ADDR_W,
    parameter int DATA_WIDTH     = TLUL_DATA_W,
    parameter int MASK_WIDTH     = TLUL_MASK_W,
    parameter int SIZE_WIDTH     = TLUL_SIZE_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_24,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_type,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [SIZE_WIDTH-1:0]   cmd_size,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [MASK_WIDTH-1:0]   cmd_mask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_type,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_error,
    output logic                    start_trans,
    output logic [1:0]              trans_type,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic [SIZE_WIDTH-1:0]   size,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic [MASK_WIDTH-1:0]   write_mask,
    input  logic                    trans_done,
    input  logic [DATA_WIDTH-1:0]   read_data,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [1:0]            ttype;
        logic [ADDR_WIDTH-1:0] addr;
        logic [SIZE_WIDTH-1:0] size;
        logic [DATA_WIDTH-1:0] wdata;
        logic [MASK_WIDTH-1:0] mask;
    } cmd_t;

    cmd_t       push_cmd;
    cmd_t       head_cmd;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    cmd_state_e state;
    cmd_state_e state_nxt;
    logic       load_issue;
    logic       load_rsvd;
    logic       cap_done;

    assign cmd_ready = (fifo_count < CNT_W'(DEPTH));
    assign push_cmd  = '{ttype: cmd_type, addr: cmd_addr, size: cmd_size,
                         wdata: cmd_wdata, mask: cmd_mask};

    tlul_sync_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk_24   (clk_24),
        .rst_n    (rst_n),
        .push     (cmd_valid && cmd_ready),
        .push_dat (push_cmd),
        .pop      (fifo_pop),
        .pop_dat  (head_cmd),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

`ifdef TLUL_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             cap_tmo;

    // Counts cycles spent in WAIT; cleared everywhere else so each issue starts at 0.
    always_ff @(posedge clk_24 or negedge rst_n) begin
        if (!rst_n)                 tmo_cnt <= '0;
        else if (state == ST_WAIT)  tmo_cnt <= tmo_cnt + 1'b1;
        else                        tmo_cnt <= '0;
    end
`endif

    always_ff @(posedge clk_24 or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        fifo_pop   = 1'b0;
        load_issue = 1'b0;
        load_rsvd  = 1'b0;
        cap_done   = 1'b0;
`ifdef TLUL_CMD_TIMEOUT_EN
        cap_tmo    = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    // Reserved type never reaches tlul_system; answer it directly.
                    if (head_cmd.ttype == TT_RSVD) begin
                        load_rsvd = 1'b1;
                        state_nxt = ST_RESP;
                    end else begin
                        load_issue = 1'b1;
                        state_nxt  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (trans_done) begin
                    cap_done  = 1'b1;
                    state_nxt = ST_RESP;
                end
`ifdef TLUL_CMD_TIMEOUT_EN
                else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    cap_tmo   = 1'b1;
                    state_nxt = ST_RESP;
                end
`endif
            end
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Master fields only change on a real issue, so they hold their last values afterwards.
    always_ff @(posedge clk_24 or negedge rst_n) begin
        if (!rst_n) begin
            trans_type <= '0;
            address    <= '0;
            size       <= '0;
            write_data <= '0;
            write_mask <= '0;
            rsp_type   <= '0;
            rsp_rdata  <= '0;
            rsp_error  <= 1'b0;
        end else begin
            if (load_issue) begin
                trans_type <= head_cmd.ttype;
                address    <= head_cmd.addr;
                size       <= head_cmd.size;
                write_data <= head_cmd.wdata;
                write_mask <= head_cmd.mask;
                rsp_type   <= head_cmd.ttype;
                rsp_rdata  <= '0;
                rsp_error  <= 1'b0;
            end
            if (load_rsvd) begin
                rsp_type  <= head_cmd.ttype;
                rsp_rdata <= '0;
                rsp_error <= 1'b1;
            end
            if (cap_done) begin
                rsp_rdata <= (trans_type == TT_GET) ? read_data : '0;
            end
`ifdef TLUL_CMD_TIMEOUT_EN
            if (cap_tmo) begin
                rsp_rdata <= '0;
                rsp_error <= 1'b1;
            end
`endif
        end
    end

    assign start_trans = (state == ST_ISSUE);
    assign rsp_valid   = (state == ST_RESP);
    assign busy        = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_tlul_cmd_queue.sv
// Directed bench for tlul_cmd_queue with a small tlul_system responder model.
module tb_tlul_cmd_queue;

    logic        clk_24;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_mask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_type;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        start_trans;
    logic [1:0]  trans_type;
    logic [31:0] address;
    logic [2:0]  size;
    logic [31:0] write_data;
    logic [3:0]  write_mask;
    logic        trans_done;
    logic [31:0] read_data;
    logic        busy;
    logic [2:0]  fifo_count;

    tlul_cmd_queue #(
        .DEPTH          (4),
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .MASK_WIDTH     (4),
        .SIZE_WIDTH     (3),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_24      (clk_24),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_type    (cmd_type),
        .cmd_addr    (cmd_addr),
        .cmd_size    (cmd_size),
        .cmd_wdata   (cmd_wdata),
        .cmd_mask    (cmd_mask),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_type    (rsp_type),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .start_trans (start_trans),
        .trans_type  (trans_type),
        .address     (address),
        .size        (size),
        .write_data  (write_data),
        .write_mask  (write_mask),
        .trans_done  (trans_done),
        .read_data   (read_data),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int          n_start  = 0;
    int          st_cyc   = 0;
    int          done_cyc = 0;
    int          acc_cyc  = 0;
    int          rsp_cyc  = 0;
    int          n_rsp    = 0;
    int          max_cnt  = 0;
    int          pend     = 0;
    logic [31:0] pend_rd;
    logic [31:0] mem [16];
    bit          slave_mute = 0;

    initial begin
        clk_24 = 1'b0;
        forever #5 clk_24 = ~clk_24;
    end

    initial forever begin
        @(posedge clk_24);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // tlul_system stand-in: completes 3 cycles after start_trans; puts return junk read_data.
    initial begin
        trans_done = 1'b0;
        read_data  = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        forever begin
            @(posedge clk_24);
            #1;
            trans_done = 1'b0;
            read_data  = '0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    trans_done = 1'b1;
                    read_data  = pend_rd;
                    done_cyc   = cyc;
                end
            end
            if (start_trans) begin
                n_start++;
                st_cyc = cyc;
                if (trans_type == 2'b00) begin
                    pend_rd = mem[address[5:2]];
                end else begin
                    pend_rd = 32'hBAD0_BAD0;
                    for (int b = 0; b < 4; b++)
                        if (write_mask[b]) mem[address[5:2]][8*b +: 8] = write_data[8*b +: 8];
                end
                pend = slave_mute ? 0 : 3;
            end
        end
    end

    initial forever begin
        @(negedge clk_24);
        if (rst_n) begin
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (rsp_valid && rsp_ready) n_rsp++;
        end
    end

    task automatic send_cmd(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m);
        bit ok = 0;
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_addr  = a;
        cmd_size  = 3'd2;
        cmd_wdata = d;
        cmd_mask  = m;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_24);
            if (cmd_ready) begin
                ok      = 1;
                acc_cyc = cyc;
                break;
            end
        end
        check("cmd accepted", ok, 1);
        @(posedge clk_24);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [1:0] et, input logic [31:0] ed,
                            input logic ee);
        bit seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_24);
            if (rsp_valid) begin
                seen = 1;
                break;
            end
        end
        rsp_cyc = cyc;
        check({tag, " rsp_valid"}, seen, 1);
        check({tag, " rsp_type"}, rsp_type, et);
        check({tag, " rsp_rdata"}, rsp_rdata, ed);
        check({tag, " rsp_error"}, rsp_error, ee);
        @(posedge clk_24);
        #1;
    endtask

    initial begin
        int  s0;
        int  r0;
        bit  ok;
        logic [31:0] rd0;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_type  = '0;
        cmd_addr  = '0;
        cmd_size  = '0;
        cmd_wdata = '0;
        cmd_mask  = '0;
        rsp_ready = 1'b1;

        repeat (3) @(negedge clk_24);
        check("reset cmd_ready", cmd_ready, 1);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset start_trans", start_trans, 0);
        check("reset fifo_count", fifo_count, 0);
        check("reset busy", busy, 0);
        check("reset address", address, 0);
        check("reset rsp_error", rsp_error, 0);
        @(posedge clk_24);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk_24);
        #1;

        // Write then read back through the responder.
        send_cmd(2'b01, 32'h4000_0000, 32'hDEAD_BEEF, 4'hF);
        s0 = acc_cyc;
        wait_rsp("putfull", 2'b01, 32'h0, 1'b0);
        check("issue latency", st_cyc - s0, 2);
        check("done to rsp latency", rsp_cyc - done_cyc, 1);
        send_cmd(2'b00, 32'h4000_0000, 32'h0, 4'h0);
        wait_rsp("get", 2'b00, 32'hDEAD_BEEF, 1'b0);
        check("one start per cmd", n_start, 2);
        @(negedge clk_24);
        check("address retained", address, 32'h4000_0000);
        check("start_trans idle", start_trans, 0);
        @(posedge clk_24);
        #1;

        // Fill the FIFO behind a stalled response.
        rsp_ready = 1'b0;
        s0 = n_start;
        send_cmd(2'b00, 32'h4000_0000, 32'h0, 4'h0);
        send_cmd(2'b01, 32'h4000_0004, 32'h1111_1111, 4'hF);
        send_cmd(2'b10, 32'h4000_0004, 32'hAABB_CCDD, 4'h3);
        send_cmd(2'b00, 32'h4000_0004, 32'h0, 4'h0);
        send_cmd(2'b00, 32'h4000_0000, 32'h0, 4'h0);
        cmd_valid = 1'b1;
        cmd_type  = 2'b00;
        cmd_addr  = 32'h4000_0008;
        ok = 1;
        repeat (5) begin
            @(negedge clk_24);
            if (cmd_ready !== 1'b0 || fifo_count !== 3'd4) ok = 0;
        end
        check("full blocks push", ok, 1);
        @(posedge clk_24);
        #1;
        cmd_valid = 1'b0;

        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_24);
            if (rsp_valid) begin
                ok = 1;
                break;
            end
        end
        check("stalled rsp seen", ok, 1);
        rd0 = rsp_rdata;
        s0  = n_start;
        ok  = 1;
        repeat (10) begin
            @(negedge clk_24);
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd0) ok = 0;
        end
        check("rsp stable under stall", ok, 1);
        check("no issue under stall", n_start, s0);
        @(posedge clk_24);
        #1;
        rsp_ready = 1'b1;
        s0 = n_start - 1;
        wait_rsp("drain0", 2'b00, 32'hDEAD_BEEF, 1'b0);
        wait_rsp("drain1", 2'b01, 32'h0, 1'b0);
        wait_rsp("drain2", 2'b10, 32'h0, 1'b0);
        wait_rsp("drain3", 2'b00, 32'h1111_CCDD, 1'b0);
        wait_rsp("drain4", 2'b00, 32'hDEAD_BEEF, 1'b0);
        check("max fifo_count", max_cnt, 4);
        check("drain starts", n_start - s0, 5);

        // Reserved type is answered locally with an error.
        s0 = n_start;
        send_cmd(2'b11, 32'h4000_0008, 32'h0, 4'h0);
        wait_rsp("rsvd", 2'b11, 32'h0, 1'b1);
        check("rsvd no start", n_start, s0);

        // Reset while a GET is waiting on tlul_system.
        slave_mute = 1;
        s0 = n_start;
        send_cmd(2'b00, 32'h4000_0004, 32'h0, 4'h0);
        for (int k = 0; k < 20 && n_start == s0; k++) @(posedge clk_24);
        check("reset test issued", n_start - s0, 1);
        repeat (2) @(posedge clk_24);
        #1;
        send_cmd(2'b01, 32'h4000_000C, 32'h5555_5555, 4'hF);
        @(negedge clk_24);
        check("pre-reset busy", busy, 1);
        check("pre-reset fifo_count", fifo_count, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset cmd_ready", cmd_ready, 1);
        check("mid reset fifo_count", fifo_count, 0);
        check("mid reset busy", busy, 0);
        check("mid reset start_trans", start_trans, 0);
        check("mid reset rsp_valid", rsp_valid, 0);
        check("mid reset address", address, 0);
        r0 = n_rsp;
        @(posedge clk_24);
        #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk_24);
        check("no rsp after reset", n_rsp, r0);
        check("idle after reset", busy, 0);
        slave_mute = 0;
        @(posedge clk_24);
        #1;

        send_cmd(2'b00, 32'h4000_0004, 32'h0, 4'h0);
        wait_rsp("post reset get", 2'b00, 32'h1111_CCDD, 1'b0);

`ifdef TLUL_CMD_TIMEOUT_EN
        slave_mute = 1;
        send_cmd(2'b00, 32'h4000_0000, 32'h0, 4'h0);
        wait_rsp("timeout", 2'b00, 32'h0, 1'b1);
        check("timeout latency", rsp_cyc - st_cyc, 17);
        slave_mute = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tlul_cmd_queue.md
Name: tlul_cmd_queue

Overview:
- Upstream command front-end for tlul_system; drives its master control port (start_trans/trans_type/address/size/write_data/write_mask; trans_done/read_data).
- Buffers requests from a CPU-side valid/ready channel in a small FIFO and issues them one at a time.
- Returns each completion on a valid/ready response channel, which removes start/done sequencing from callers.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >=2)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- MASK_WIDTH, 4, byte-mask width (DATA_WIDTH/8)
- SIZE_WIDTH, 3, log2 bytes field
- TIMEOUT_CYCLES, 255, watchdog limit (used only with optional feature)

Ports:
- clk_24  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  request valid
- cmd_ready  out  1  request accepted when valid&ready
- cmd_type  in  2  00 GET, 01 PUTFULL, 10 PUTPARTIAL, 11 reserved
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_size  in  SIZE_WIDTH  transfer size
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_mask  in  MASK_WIDTH  write byte mask
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&ready
- rsp_type  out  2  echo of cmd_type
- rsp_rdata  out  DATA_WIDTH  read data (GET); 0 otherwise
- rsp_error  out  1  reserved type or timeout
- start_trans  out  1  one-cycle issue pulse to tlul_system
- trans_type  out  2  to tlul_system
- address  out  ADDR_WIDTH  to tlul_system
- size  out  SIZE_WIDTH  to tlul_system
- write_data  out  DATA_WIDTH  to tlul_system
- write_mask  out  MASK_WIDTH  to tlul_system
- trans_done  in  1  completion pulse from tlul_system
- read_data  in  DATA_WIDTH  read result, valid with trans_done
- busy  out  1  FIFO non-empty or FSM not IDLE
- fifo_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset, asynchronous: all outputs 0 except cmd_ready=1. FIFO flushed, FSM in IDLE.
- Reset mid-transaction abandons the in-flight command. tlul_system shares rst_n.
- cmd_ready = (fifo_count < DEPTH), combinational from count. Push when cmd_valid&cmd_ready.
- Push and pop in the same cycle: count unchanged.
- Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into issue registers. Reserved type goes to RESP with rsp_error=1 and issues nothing. Otherwise go to ISSUE.
  - ISSUE: start_trans=1 for exactly this cycle, master fields driven from registers. Go to WAIT.
  - WAIT: master fields held stable. On trans_done=1, capture read_data (GET) or 0 (puts) into rsp_rdata and go to RESP.
  - RESP: rsp_valid=1 with rsp_type/rsp_rdata/rsp_error stable until rsp_ready. On handshake, rsp_valid drops next cycle and FSM returns to IDLE.
- trans_done is ignored in IDLE, ISSUE and RESP.
- Latency, empty FIFO, ready consumer:
  - cmd accepted at cycle N → start_trans at N+2.
  - trans_done at M → rsp_valid at M+1.
- Throughput: one outstanding transaction. Next issue no earlier than 2 cycles after the response handshake.
- Master fields retain their last values after completion; start_trans stays 0.
- Backpressure on rsp_ready stalls issue. The FIFO keeps accepting commands until full.

Optional Feature:
- Macro TLUL_CMD_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - After TIMEOUT_CYCLES cycles without trans_done, go to RESP with rsp_error=1 and rsp_rdata=0.
  - A late trans_done arriving outside WAIT is ignored.
- Undefined: no counter; WAIT waits indefinitely. rsp_error is set only for the reserved type.

Decomposition:
- Package tlul_pkg holds:
  - trans-type encodings: GET=2'b00, PUTFULL=2'b01, PUTPARTIAL=2'b10, RSVD=2'b11
  - FSM state encodings
  - width defaults
- Sub-module tlul_sync_fifo: parameterised width/depth, push/pop/full/empty/count. It stores the packed {type,addr,size,wdata,mask} entry.

Test Plan:
- PUTFULL 0x40000000/0xDEADBEEF/mask 0xF, then GET 0x40000000, through tlul_system → two responses in order. Second response has rsp_rdata=0xDEADBEEF, rsp_error=0, exactly one start_trans per command.
- Push 5 commands back-to-back with DEPTH=4 and rsp_ready=0 → cmd_ready falls once fifo_count=4 is reached. fifo_count never exceeds 4. The FIFO drains in order once rsp_ready=1.
- cmd_type=2'b11 at 0x40000008 → no start_trans. Response has rsp_error=1, rsp_rdata=0.
- Hold rsp_ready=0 for 10 cycles during RESP → rsp_valid/rsp_rdata stable. No new start_trans until the handshake.
- Deassert rst_n during WAIT of GET 0x40000004 → outputs return to reset values immediately. fifo_count=0, no response.
- With TLUL_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16, trans_done never asserted → rsp_valid with rsp_error=1 at the 17th cycle after start_trans.
